// File: rtl/neuron_pkg.sv
// Shared constants and FSM encoding for the neuron core and its downstream monitors.
// Potentials are signed Q12.9 fixed point.
package neuron_pkg;

    localparam int W     = 21;
    localparam int FRAC  = 9;
    localparam int ONE_Q = 1 << FRAC;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        FIRED   = 2'd1,
        REFRACT = 2'd2
    } spike_state_e;

endpackage

// File: rtl/spike_ts_fifo.sv
// First-word fall-through timestamp FIFO with occupancy tracking and drop reporting.
// A push into a full FIFO survives only if a pop frees a slot on the same edge.
module spike_ts_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          set,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] last_q;
    logic          empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (set) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (!empty) last_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Once drained, the output keeps the last head seen rather than a stale slot.
    assign data_o  = empty ? last_q : mem_q[rd_ptr_q];
    assign valid_o = !empty;

endmodule

// File: rtl/spike_monitor.sv
// Threshold-crossing spike detector with hysteresis, refractory hold-off,
// timestamped spike FIFO, saturating spike count and sticky overflow flag.
module spike_monitor
    import neuron_pkg::*;
#(
    parameter int W          = neuron_pkg::W,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int REFRAC     = 4
) (
    input  logic            clk,
    input  logic            set,
    input  logic            en,
    input  logic [W-1:0]    v,
    input  logic [W-1:0]    vth,
    input  logic [W-1:0]    vhyst,
    output logic            spike,
    output logic [TS_W-1:0] ts_data,
    output logic            ts_valid,
    input  logic            ts_ready,
    output logic [TS_W-1:0] spike_count,
    output logic            overflow,
    output logic [1:0]      state_dbg
);

    localparam int RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    spike_state_e    state_q, state_d;
    logic [RC_W-1:0] rcnt_q, rcnt_d;
    logic [TS_W-1:0] tnow_q, count_q;
    logic            spike_q, overflow_q;
    logic            fire, drop, pop;

    // Lower bound carried at W+2 bits so vth - vhyst can never wrap.
    logic signed [W+1:0] vlo, v_ext;
    logic                ge_th, below_lo;

    assign vlo      = {{2{vth[W-1]}}, vth} - {2'b00, vhyst};
    assign v_ext    = {{2{v[W-1]}}, v};
    assign ge_th    = ($signed(v) >= $signed(vth));
    assign below_lo = (v_ext < vlo);

    always_ff @(posedge clk) begin
        if (set) begin
            state_q <= ARMED;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        if (en) begin
            case (state_q)
                ARMED: begin
                    if (ge_th) state_d = FIRED;
                end
                FIRED: begin
                    if (below_lo) begin
                        if (REFRAC == 0) begin
                            state_d = ARMED;
                        end else begin
                            state_d = REFRACT;
                            rcnt_d  = RC_W'(REFRAC);
                        end
                    end
                end
                REFRACT: begin
                    if (rcnt_q <= RC_W'(1)) begin
                        state_d = ARMED;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q - RC_W'(1);
                    end
                end
                default: begin
                    state_d = ARMED;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        fire = en && (state_q == ARMED) && ge_th;
    end

    always_ff @(posedge clk) begin
        if (set) begin
            tnow_q     <= '0;
            spike_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (en) tnow_q <= tnow_q + TS_W'(1);
            spike_q <= fire;
            if (fire && (count_q != '1)) count_q <= count_q + TS_W'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign pop = ts_valid && ts_ready;

    spike_ts_fifo #(
        .DW    (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .set     (set),
        .push_i  (fire),
        .data_i  (tnow_q),
        .pop_i   (pop),
        .data_o  (ts_data),
        .valid_o (ts_valid),
        .drop_o  (drop)
    );

    assign spike       = spike_q;
    assign spike_count = count_q;
    assign overflow    = overflow_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_spike_monitor.sv
// Directed bench for spike_monitor: reset, crossing, hysteresis/refractory,
// FIFO overflow and simultaneous push/pop, timestamp wrap and enable freeze.
module tb_spike_monitor;
    import neuron_pkg::*;

    logic        clk = 1'b0;
    logic        set, en, ts_ready;
    logic [20:0] v, vth, vhyst;

    logic        spike, ts_valid, overflow;
    logic [15:0] ts_data, spike_count;
    logic [1:0]  state_dbg;

    logic        spike4, ts_valid4, overflow4;
    logic [3:0]  ts_data4, spike_count4;
    logic [1:0]  state4;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          sp;
    logic [15:0] exp_q[$];
    logic [15:0] exp_ts;

    always #5 clk = ~clk;

    spike_monitor #(.TS_W(16), .FIFO_DEPTH(4), .REFRAC(4)) dut (
        .clk(clk), .set(set), .en(en), .v(v), .vth(vth), .vhyst(vhyst),
        .spike(spike), .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
        .spike_count(spike_count), .overflow(overflow), .state_dbg(state_dbg)
    );

    spike_monitor #(.TS_W(4), .FIFO_DEPTH(4), .REFRAC(4)) dut4 (
        .clk(clk), .set(set), .en(en), .v(v), .vth(vth), .vhyst(vhyst),
        .spike(spike4), .ts_data(ts_data4), .ts_valid(ts_valid4), .ts_ready(ts_ready),
        .spike_count(spike_count4), .overflow(overflow4), .state_dbg(state4)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        // 1: reset
        set = 1'b1; en = 1'b1; v = 21'd0; vth = 21'd15360; vhyst = 21'd0; ts_ready = 1'b0;
        tick(2);
        check("rst_spike", 32'(spike), 0);
        check("rst_valid", 32'(ts_valid), 0);
        check("rst_data", 32'(ts_data), 0);
        check("rst_count", 32'(spike_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_state", 32'(state_dbg), 32'(ARMED));
        set = 1'b0;

        // 2: single crossing at tnow=10
        v = 21'd15359;
        tick(10);
        check("pre_count", 32'(spike_count), 0);
        check("pre_valid", 32'(ts_valid), 0);
        v = 21'd15360;
        tick(1);
        check("x_spike", 32'(spike), 1);
        check("x_valid", 32'(ts_valid), 1);
        check("x_data", 32'(ts_data), 10);
        check("x_count", 32'(spike_count), 1);
        check("x_state", 32'(state_dbg), 32'(FIRED));
        tick(1);
        check("x_pulse_end", 32'(spike), 0);
        sp = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (spike) sp++;
        end
        check("hold_no_spike", 32'(sp), 0);
        check("hold_count", 32'(spike_count), 1);

        // 3: hysteresis and refractory; vlo = 14336
        vhyst = 21'd1024;
        v = 21'd14337;
        tick(5);
        check("hyst_state", 32'(state_dbg), 32'(FIRED));
        check("hyst_count", 32'(spike_count), 1);
        v = 21'd14335;
        tick(1);
        check("refr_enter", 32'(state_dbg), 32'(REFRACT));
        v = 21'd16000;
        sp = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (spike) sp++;
        end
        check("refr_ignored", 32'(sp), 0);
        check("refr_rearm", 32'(state_dbg), 32'(ARMED));
        tick(1);
        check("rearm_spike", 32'(spike), 1);
        check("rearm_count", 32'(spike_count), 2);
        check("rearm_head", 32'(ts_data), 10);

        // 4: mid-operation reset with v high, then overflow
        set = 1'b1;
        tick(2);
        check("mrst_spike", 32'(spike), 0);
        check("mrst_valid", 32'(ts_valid), 0);
        check("mrst_count", 32'(spike_count), 0);
        check("mrst_state", 32'(state_dbg), 32'(ARMED));
        set = 1'b0; v = 21'd0; vhyst = 21'd0;
        for (int k = 0; k < 5; k++) begin
            tick(k == 0 ? 5 : 14);
            v = 21'd15360;
            tick(1);
            v = 21'd0;
            if (k < 4) exp_q.push_back(16'(5 + 15 * k));
            if (k == 3) check("ovf_at_full", 32'(overflow), 0);
        end
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(spike_count), 5);
        check("ovf_valid", 32'(ts_valid), 1);
        ts_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ts = exp_q.pop_front();
            check("drain_data", 32'(ts_data), 32'(exp_ts));
            tick(1);
        end
        check("drain_empty", 32'(ts_valid), 0);
        check("drain_hold", 32'(ts_data), 50);
        check("drain_ovf_sticky", 32'(overflow), 1);

        // 5: full FIFO with simultaneous push and pop
        set = 1'b1; ts_ready = 1'b0;
        tick(2);
        set = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(k == 0 ? 5 : 14);
            v = 21'd15360;
            tick(1);
            v = 21'd0;
            exp_q.push_back(16'(5 + 15 * k));
        end
        tick(14);
        v = 21'd15360; ts_ready = 1'b1;
        tick(1);
        v = 21'd0;
        exp_q.push_back(16'd65);
        exp_ts = exp_q.pop_front();
        check("pp_ovf", 32'(overflow), 0);
        check("pp_count", 32'(spike_count), 5);
        for (int i = 0; i < 4; i++) begin
            exp_ts = exp_q.pop_front();
            check("pp_data", 32'(ts_data), 32'(exp_ts));
            tick(1);
        end
        check("pp_empty", 32'(ts_valid), 0);
        check("pp_ovf_end", 32'(overflow), 0);

        // 6: timestamp wrap on the 4-bit instance and enable freeze
        set = 1'b1; ts_ready = 1'b1; v = 21'd0;
        tick(2);
        set = 1'b0;
        tick(17);
        v = 21'd15360;
        tick(1);
        v = 21'd0;
        check("wrap_spike", 32'(spike4), 1);
        check("wrap_data", 32'(ts_data4), 1);
        check("wrap_wide", 32'(ts_data), 17);
        tick(6);
        check("wrap_armed", 32'(state4), 32'(ARMED));
        check("wrap_hold", 32'(ts_data4), 1);
        en = 1'b0; v = 21'd15360;
        sp = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (spike4) sp++;
        end
        check("en0_no_spike", 32'(sp), 0);
        check("en0_state", 32'(state4), 32'(ARMED));
        check("en0_count", 32'(spike_count4), 1);
        en = 1'b1;
        tick(1);
        check("en1_spike", 32'(spike4), 1);
        check("en1_data", 32'(ts_data4), 8);
        check("en1_wide", 32'(ts_data), 24);
        check("en1_count", 32'(spike_count4), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
